// File: rtl/frame_segmenter.sv
// frame_segmenter
//   Cuts a continuous 18-bit sample stream into overlapping frames of N = 2^LOGSIZE samples,
//   one frame every H = 2^HOPLOG samples, and replays each frame oldest-first for a
//   downstream window/FFT stage.
//
//   Samples land in a 2N-deep circular buffer that is written on every sample_valid,
//   with no stall in any state. Once N samples have been primed, every H-th write
//   snapshots a frame base. The frame is then read out over N back-to-back cycles.
//   A frame triggered while another is streaming waits in a one-deep pending slot.
//   A trigger that finds that slot already full is dropped and flagged on overrun.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   sample_valid one-cycle strobe qualifying sample_in
//   sample_in    two's-complement audio sample
//   data_out     frame sample, oldest first; holds its last value while out_valid is low
//   out_valid    data_out / out_index valid this cycle
//   out_index    position of data_out within the frame, 0..N-1
//   frame_start  out_valid with out_index == 0
//   frame_end    out_valid with out_index == N-1
//   overrun      one-cycle pulse when a frame trigger is dropped
module frame_segmenter #(
   parameter int unsigned LOGSIZE = 9,
   parameter int unsigned HOPLOG  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_valid,
   input  logic [17:0]        sample_in,
   output logic [17:0]        data_out,
   output logic               out_valid,
   output logic [LOGSIZE-1:0] out_index,
   output logic               frame_start,
   output logic               frame_end,
   output logic               overrun
);

   localparam int unsigned N     = 1 << LOGSIZE;
   localparam int unsigned H     = 1 << HOPLOG;
   localparam int unsigned AW    = LOGSIZE + 1;
   localparam int unsigned Depth = 2 * N;

   localparam logic [AW-1:0]      NPtr    = AW'(N);
   localparam logic [LOGSIZE-1:0] LastIdx = LOGSIZE'(N - 1);
   localparam logic [HOPLOG-1:0]  LastHop = HOPLOG'(H - 1);

   typedef enum logic [1:0] {
      StPrime,
      StIdle,
      StStream
   } state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LOGSIZE-1:0] prime_cnt_q, prime_cnt_d;
   logic [HOPLOG-1:0]  hop_cnt_q, hop_cnt_d;
   logic [AW-1:0]      base_q, base_d;
   logic [LOGSIZE-1:0] k_q, k_d;
   logic               pend_valid_q, pend_valid_d;
   logic [AW-1:0]      pend_base_q, pend_base_d;

   // Read pipeline stage aligned with the synchronous RAM output.
   logic               v1_q, v1_d;
   logic [LOGSIZE-1:0] idx1_q, idx1_d;

   // Registered outputs.
   logic [17:0]        data_out_q, data_out_d;
   logic               out_valid_q, out_valid_d;
   logic [LOGSIZE-1:0] out_index_q, out_index_d;
   logic               frame_start_q, frame_start_d;
   logic               frame_end_q, frame_end_d;
   logic               overrun_q, overrun_d;

   logic               trigger;
   logic               frame_last;
   logic [AW-1:0]      new_base;
   logic [AW-1:0]      rd_addr;

   // Sample buffer: one write port, one registered read port.
   logic [17:0]        mem [Depth];
   logic [17:0]        rd_data_q;

   assign rd_addr = base_q + AW'(k_q);

   // Read and write in the same block so a same-address collision returns the old word.
   // Back-to-back pending frames rely on this on their tightest cycle.
   always_ff @(posedge clk) begin
      if (reset && sample_valid) begin
         mem[wr_ptr_q] <= sample_in;
      end
      rd_data_q <= mem[rd_addr];
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      prime_cnt_d  = prime_cnt_q;
      hop_cnt_d    = hop_cnt_q;
      base_d       = base_q;
      k_d          = k_q;
      pend_valid_d = pend_valid_q;
      pend_base_d  = pend_base_q;
      overrun_d    = 1'b0;
      trigger      = 1'b0;

      // Base of the N most recent samples including this write; +N == -N modulo 2N.
      new_base   = wr_ptr_q + AW'(1) + NPtr;
      frame_last = (k_q == LastIdx);

      if (sample_valid) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (state_q == StPrime) begin
            prime_cnt_d = prime_cnt_q + LOGSIZE'(1);
            trigger     = (prime_cnt_q == LastIdx);
         end else begin
            hop_cnt_d = hop_cnt_q + HOPLOG'(1);
            trigger   = (hop_cnt_q == LastHop);
         end
      end

      case (state_q)
         StPrime, StIdle: begin
            if (trigger) begin
               state_d = StStream;
               base_d  = new_base;
               k_d     = '0;
            end
         end
         StStream: begin
            if (frame_last) begin
               k_d = '0;
               if (pend_valid_q) begin
                  // Chain the pending frame; a trigger on this same edge refills the slot.
                  base_d       = pend_base_q;
                  pend_valid_d = trigger;
                  if (trigger) begin
                     pend_base_d = new_base;
                  end
               end else if (trigger) begin
                  base_d = new_base;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               k_d = k_q + LOGSIZE'(1);
               if (trigger) begin
                  if (!pend_valid_q) begin
                     pend_valid_d = 1'b1;
                     pend_base_d  = new_base;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = StPrime;
         end
      endcase

      // Stage 1 follows the address issue; stage 2 follows the RAM read.
      v1_d   = (state_q == StStream);
      idx1_d = k_q;

      out_valid_d   = v1_q;
      frame_start_d = v1_q && (idx1_q == '0);
      frame_end_d   = v1_q && (idx1_q == LastIdx);
      out_index_d   = v1_q ? idx1_q : out_index_q;
      data_out_d    = v1_q ? rd_data_q : data_out_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StPrime;
         wr_ptr_q      <= '0;
         prime_cnt_q   <= '0;
         hop_cnt_q     <= '0;
         base_q        <= '0;
         k_q           <= '0;
         pend_valid_q  <= 1'b0;
         pend_base_q   <= '0;
         v1_q          <= 1'b0;
         idx1_q        <= '0;
         data_out_q    <= '0;
         out_valid_q   <= 1'b0;
         out_index_q   <= '0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         prime_cnt_q   <= prime_cnt_d;
         hop_cnt_q     <= hop_cnt_d;
         base_q        <= base_d;
         k_q           <= k_d;
         pend_valid_q  <= pend_valid_d;
         pend_base_q   <= pend_base_d;
         v1_q          <= v1_d;
         idx1_q        <= idx1_d;
         data_out_q    <= data_out_d;
         out_valid_q   <= out_valid_d;
         out_index_q   <= out_index_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         overrun_q     <= overrun_d;
      end
   end

   assign data_out    = data_out_q;
   assign out_valid   = out_valid_q;
   assign out_index   = out_index_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_segmenter.sv
// Bench for frame_segmenter with N = 8, H = 4 and ramp samples.
module tb_frame_segmenter;

   localparam int unsigned LOGSIZE = 3;
   localparam int unsigned HOPLOG  = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_valid;
   logic [17:0]        sample_in;
   logic [17:0]        data_out;
   logic               out_valid;
   logic [LOGSIZE-1:0] out_index;
   logic               frame_start;
   logic               frame_end;
   logic               overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   frame_segmenter #(
      .LOGSIZE (LOGSIZE),
      .HOPLOG  (HOPLOG)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .out_index    (out_index),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .overrun      (overrun)
   );

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [17:0] v);
      sample_valid = 1'b1;
      sample_in    = v;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      repeat (3) tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (data_out !== 18'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
      total++; if (out_index !== 3'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", out_index); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", frame_start); end
      total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", frame_end); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_prime();
      reset = 1'b1;
      tick();
      for (int s = 1; s <= 7; s++) begin
         send(18'(s));
         for (int c = 0; c < 4; c++) begin
            total++;
            if (out_valid !== 1'b0) begin
               bad++; $display("FAIL prime_early s=%0d c=%0d: got %b want 0", s, c, out_valid);
            end
            if (c < 3) tick();
         end
      end
      send(18'd8);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prime_lat0: got %b want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prime_lat1: got %b want 0", out_valid); end
      tick();
      for (int k = 0; k < 8; k++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL prime_valid k=%0d: got %b want 1", k, out_valid); end
         total++; if (data_out !== 18'(k + 1)) begin bad++; $display("FAIL prime_data k=%0d: got %0d want %0d", k, data_out, k + 1); end
         total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL prime_index k=%0d: got %0d want %0d", k, out_index, k); end
         total++; if (frame_start !== (k == 0)) begin bad++; $display("FAIL prime_start k=%0d: got %b", k, frame_start); end
         total++; if (frame_end !== (k == 7)) begin bad++; $display("FAIL prime_end k=%0d: got %b", k, frame_end); end
         tick();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prime_after: got %b want 0", out_valid); end
   endtask

   // Samples 9..20 spaced 20 cycles apart; frames follow samples 12, 16 and 20.
   task automatic test_hop();
      for (int s = 9; s <= 20; s++) begin
         bit trig;
         trig = (s % 4 == 0);
         send(18'(s));
         for (int c = 0; c < 20; c++) begin
            bit exp_v;
            int k;
            exp_v = trig && (c >= 2) && (c <= 9);
            k     = c - 2;
            total++;
            if (out_valid !== exp_v) begin
               bad++; $display("FAIL hop_valid s=%0d c=%0d: got %b want %b", s, c, out_valid, exp_v);
            end
            if (exp_v) begin
               total++; if (data_out !== 18'(s - 7 + k)) begin bad++; $display("FAIL hop_data s=%0d k=%0d: got %0d want %0d", s, k, data_out, s - 7 + k); end
               total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL hop_index s=%0d: got %0d want %0d", s, out_index, k); end
               total++; if (frame_start !== (k == 0)) begin bad++; $display("FAIL hop_start s=%0d k=%0d: got %b", s, k, frame_start); end
               total++; if (frame_end !== (k == 7)) begin bad++; $display("FAIL hop_end s=%0d k=%0d: got %b", s, k, frame_end); end
            end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL hop_overrun s=%0d c=%0d: got %b want 0", s, c, overrun); end
            tick();
         end
      end
   endtask

   // Sample e written at edge e for e = 1..32. Frames ending at samples 8, 12, 16, 24, 32
   // stream contiguously on edges 10..49; triggers at 20 and 28 are dropped.
   task automatic test_back_to_back();
      int last_s [5];
      last_s = '{8, 12, 16, 24, 32};
      reset = 1'b0;
      sample_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      for (int e = 1; e <= 55; e++) begin
         bit exp_v;
         bit exp_ov;
         int f;
         int k;
         sample_valid = (e <= 32);
         sample_in    = 18'(e);
         tick();
         exp_v  = (e >= 10) && (e <= 49);
         exp_ov = (e == 20) || (e == 28);
         f = (e - 10) / 8;
         k = (e - 10) % 8;
         total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid e=%0d: got %b want %b", e, out_valid, exp_v); end
         total++; if (overrun !== exp_ov) begin bad++; $display("FAIL b2b_overrun e=%0d: got %b want %b", e, overrun, exp_ov); end
         if (exp_v) begin
            total++; if (data_out !== 18'(last_s[f] - 7 + k)) begin bad++; $display("FAIL b2b_data e=%0d: got %0d want %0d", e, data_out, last_s[f] - 7 + k); end
            total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL b2b_index e=%0d: got %0d want %0d", e, out_index, k); end
            total++; if (frame_start !== (k == 0)) begin bad++; $display("FAIL b2b_start e=%0d: got %b", e, frame_start); end
            total++; if (frame_end !== (k == 7)) begin bad++; $display("FAIL b2b_end e=%0d: got %b", e, frame_end); end
         end
      end
      sample_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         sample_valid = 1'b1;
         sample_in    = 18'(s);
         tick();
      end
      sample_valid = 1'b0;
      repeat (5) tick();
      total++; if (out_index !== 3'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre: got idx %0d valid %b want idx 3 valid 1", out_index, out_valid); end
      // Sample coincident with reset must be discarded.
      reset        = 1'b0;
      sample_valid = 1'b1;
      sample_in    = 18'd999;
      tick();
      reset        = 1'b1;
      sample_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_abort_valid: got %b want 0", out_valid); end
      total++; if (data_out !== 18'h0) begin bad++; $display("FAIL mid_abort_data: got %h want 0", data_out); end
      total++; if (out_index !== 3'd0) begin bad++; $display("FAIL mid_abort_index: got %0d want 0", out_index); end
      for (int s = 101; s <= 107; s++) begin
         sample_valid = 1'b1;
         sample_in    = 18'(s);
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reprime s=%0d: got %b want 0", s, out_valid); end
      end
      sample_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         total++; if (out_valid !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL mid_idle c=%0d: got valid %b start %b want 0", c, out_valid, frame_start); end
      end
      send(18'd108);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_lat1: got %b want 0", out_valid); end
      tick();
      for (int k = 0; k < 8; k++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid k=%0d: got %b want 1", k, out_valid); end
         total++; if (data_out !== 18'(101 + k)) begin bad++; $display("FAIL mid_data k=%0d: got %0d want %0d", k, data_out, 101 + k); end
         total++; if (frame_start !== (k == 0)) begin bad++; $display("FAIL mid_start k=%0d: got %b", k, frame_start); end
         tick();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_after: got %b want 0", out_valid); end
   endtask

   task automatic test_sign();
      logic [17:0] vec [8];
      vec = '{18'd1, 18'd2, 18'h3FFFF, 18'd4, 18'd5, 18'h20000, 18'd7, 18'd8};
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 0; s < 8; s++) begin
         sample_valid = 1'b1;
         sample_in    = vec[s];
         tick();
      end
      sample_valid = 1'b0;
      repeat (2) tick();
      for (int k = 0; k < 8; k++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sign_valid k=%0d: got %b want 1", k, out_valid); end
         total++; if (data_out !== vec[k]) begin bad++; $display("FAIL sign_data k=%0d: got %h want %h", k, data_out, vec[k]); end
         total++; if (out_index !== 3'(k)) begin bad++; $display("FAIL sign_index k=%0d: got %0d want %0d", k, out_index, k); end
         tick();
      end
      // Data holds the last sample once the frame ends.
      total++; if (out_valid !== 1'b0 || data_out !== 18'd8) begin bad++; $display("FAIL sign_hold: got valid %b data %h want 0 / 8", out_valid, data_out); end
   endtask

   initial begin
      test_reset();
      test_prime();
      test_hop();
      test_back_to_back();
      test_reset_mid_frame();
      test_sign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_segmenter.md
FRAME_SEGMENTER -- requirements
Module: frame_segmenter

Interface
REQ-001 Parameter LOGSIZE, default 9, log2 of frame length N (N = 2^LOGSIZE samples).
REQ-002 Parameter HOPLOG, default 8, log2 of hop H (H = 2^HOPLOG); HOPLOG < LOGSIZE.
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-005 Port sample_valid  input  1  one-cycle strobe: sample_in holds a new audio sample.
REQ-006 Port sample_in  input  18  two's-complement audio sample.
REQ-007 Port data_out  output  18  frame sample, oldest first, bit-exact copy of stored sample.
REQ-008 Port out_valid  output  1  data_out/out_index valid this cycle.
REQ-009 Port out_index  output  LOGSIZE  position of data_out within the frame, 0..N-1, for the window stage's coefficient lookup.
REQ-010 Port frame_start  output  1  high with out_valid when out_index==0.
REQ-011 Port frame_end  output  1  high with out_valid when out_index==N-1.
REQ-012 Port overrun  output  1  one-cycle pulse when a frame trigger is dropped.

Function
REQ-013 Storage: circular buffer, depth 2N x 18, single write port, synchronous read port (1-cycle read latency).
REQ-014 Each sample_valid writes sample_in at wr_ptr; wr_ptr increments modulo 2N; writes never stall, in any state.
REQ-015 FSM states: PRIME, IDLE, STREAM.
REQ-016 PRIME: counts written samples; on the edge writing the Nth sample since reset, raise a trigger; go to STREAM.
REQ-017 IDLE/STREAM: hop counter counts writes modulo H; the edge writing the Hth sample since the last trigger raises a trigger.
REQ-018 Trigger snapshot base = (wr_ptr after that write) - N, modulo 2N; frame = the N most recent samples.
REQ-019 Trigger in IDLE: enter STREAM next edge, read address = base.
REQ-020 STREAM: read address = base+k, k = 0..N-1 over N consecutive cycles, no gaps.
REQ-021 out_valid first high 2 cycles after the triggering write edge; stays high exactly N consecutive cycles; out_index = k delayed to match read latency.
REQ-022 Trigger during STREAM: store base in one-deep pending slot; on the cycle after frame_end, start the pending frame with no idle cycle between frames.
REQ-023 Trigger while pending slot full: drop it, pulse overrun for one cycle, keep existing pending base.
REQ-024 After frame_end with no pending frame: return to IDLE; out_valid low.
REQ-025 Write during STREAM to an address still unread in the current frame is impossible for H <= N and sample spacing >= 1 cycle; no special handling.
REQ-026 data_out held at last value when out_valid low; downstream shall ignore it.

Reset
REQ-027 On reset==0 edge: state=PRIME, wr_ptr=0, prime and hop counters=0, pending slot empty, out_valid=0, frame_start=0, frame_end=0, overrun=0, out_index=0, data_out=0.
REQ-028 Reset mid-frame aborts the frame: out_valid low from the following cycle; a new frame requires N fresh samples.
REQ-029 A sample_valid coincident with reset==0 is discarded.

Verification (bench with LOGSIZE=3, HOPLOG=2: N=8, H=4; samples are ramp 1,2,3,...)
REQ-030 Prime: 7 samples -> out_valid never high; 8th sample -> 8 valid cycles with data 1..8, out_index 0..7, frame_start at 0, frame_end at 7, first valid 2 cycles after the 8th write.
REQ-031 Hop and wrap: continue to sample 20, spaced 20 cycles apart -> frames 5..12, 9..16, 13..20, each starting 2 cycles after samples 12, 16, 20.
REQ-032 Back-to-back: after priming, sample_valid every cycle -> frames contiguous (frame_end then frame_start next cycle), overrun pulses on each trigger arriving while a frame is pending, and no frame data corrupted.
REQ-033 Reset mid-frame: reset low during out_index==3 -> out_valid 0 the next cycle; 8 new samples needed before next frame_start.
REQ-034 Sign integrity: samples 18'h3FFFF and 18'h20000 appear unchanged on data_out at the correct out_index.
